small_cdb_fifo: RTL and testbench

SMALL_CDB_FIFO -- requirements
Module: small_cdb_fifo

---
 rtl/small_cdb_fifo.sv | 140 ++++++++++++++
 tb/tb_small_cdb_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/small_cdb_fifo.sv
// Small result FIFO between a functional unit and the big CDB queue, with branch-mask
// resolution and squash on the fly. Define SMALL_CDB_FIFO_BYPASS_EN for same-cycle empty bypass.
package small_cdb_fifo_pkg;
    localparam int EBR_MASK_SIZE = 4;
    localparam int TAG_W         = 6;
    localparam int PAYLOAD_W     = 16;

    typedef struct packed {
        logic                     valid;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
        logic [TAG_W-1:0]         tag;
        logic [PAYLOAD_W-1:0]     data;
    } cdb_t;
endpackage

module small_cdb_fifo
    import small_cdb_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  cdb_t                     in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output cdb_t                     out_data,
    input  logic                     out_pop,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]              r_head;
    logic [AW:0]              r_tail;
    logic [DEPTH-1:0]         r_vld;
    logic [EBR_MASK_SIZE-1:0] r_mask [DEPTH];
    logic [TAG_W-1:0]         r_tag  [DEPTH];
    logic [PAYLOAD_W-1:0]     r_data [DEPTH];

    logic [AW-1:0]            w_head_idx;
    logic [AW-1:0]            w_tail_idx;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_in_kill;
    logic [EBR_MASK_SIZE-1:0] w_in_mask;
    logic                     w_head_vld;
    logic                     w_head_kill;
    logic [EBR_MASK_SIZE-1:0] w_head_mask;
    logic                     w_q_valid;
    logic                     w_auto_pop;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    cdb_t                     w_q_out;

    assign w_head_idx = r_head[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[AW] != r_tail[AW]) && (w_head_idx == w_tail_idx);
    assign in_ready   = !w_full;
    assign count      = r_tail - r_head;
    assign w_accept   = in_valid && !w_full;

    // Resolve the incoming entry against a branch resolving this same cycle.
    assign w_in_kill = bra_done && bra_mispredict && (|(in_data.ebr_mask & bra_id));
    assign w_in_mask = bra_done ? (in_data.ebr_mask & ~bra_id) : in_data.ebr_mask;

    assign w_head_vld  = r_vld[w_head_idx];
    assign w_head_kill = bra_done && bra_mispredict && (|(r_mask[w_head_idx] & bra_id));
    assign w_head_mask = bra_done ? (r_mask[w_head_idx] & ~bra_id) : r_mask[w_head_idx];
    assign w_q_valid   = !w_empty && w_head_vld && !w_head_kill;
    // A head already squashed in an earlier cycle just occupies a slot; drop it silently.
    assign w_auto_pop  = !w_empty && !w_head_vld;
    assign w_pop       = (out_pop && w_q_valid) || w_auto_pop;

    always_comb begin
        w_q_out          = '0;
        w_q_out.valid    = w_q_valid;
        w_q_out.ebr_mask = w_head_mask;
        w_q_out.tag      = r_tag[w_head_idx];
        w_q_out.data     = r_data[w_head_idx];
    end

`ifdef SMALL_CDB_FIFO_BYPASS_EN
    logic w_bypass;
    cdb_t w_byp_out;

    assign w_bypass = w_empty && in_valid && !w_in_kill && in_data.valid;

    always_comb begin
        w_byp_out          = in_data;
        w_byp_out.ebr_mask = w_in_mask;
    end

    assign out_valid = w_q_valid || w_bypass;
    assign out_data  = w_bypass ? w_byp_out : w_q_out;
    // An entry consumed straight through the bypass is never written.
    assign w_push    = w_accept && !w_in_kill && !(w_bypass && out_pop);
`else
    assign out_valid = w_q_valid;
    assign out_data  = w_q_out;
    assign w_push    = w_accept && !w_in_kill;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bra_done && bra_mispredict && (|(r_mask[i] & bra_id)))
                    r_vld[i] <= 1'b0;
            end
            if (w_push) begin
                r_vld[w_tail_idx] <= in_data.valid;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
        end
    end

    // Payload and masks carry no reset; the valid bits and pointers qualify them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (bra_done)
                r_mask[i] <= r_mask[i] & ~bra_id;
        end
        if (w_push) begin
            r_mask[w_tail_idx] <= w_in_mask;
            r_tag[w_tail_idx]  <= in_data.tag;
            r_data[w_tail_idx] <= in_data.data;
        end
    end

endmodule

// File: tb/tb_small_cdb_fifo.sv
// Bench for small_cdb_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_small_cdb_fifo;
    import small_cdb_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    cdb_t       in_data;
    logic       in_ready;
    logic       out_valid;
    cdb_t       out_data;
    logic       out_pop;
    logic       bra_done;
    logic       bra_mispredict;
    logic [3:0] bra_id;
    logic [2:0] count;

    small_cdb_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_pop(out_pop),
        .bra_done(bra_done), .bra_mispredict(bra_mispredict), .bra_id(bra_id),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [3:0]  m;
        bit [5:0]  tag;
        bit [15:0] d;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit        e_ov;
    bit        e_ir;
    bit [3:0]  e_m;
    bit [5:0]  e_tag;
    bit [15:0] e_d;
    int        e_cnt;

    function automatic bit in_survives();
        return !(bra_done && bra_mispredict && ((in_data.ebr_mask & bra_id) != 4'd0));
    endfunction

    function automatic bit byp_case();
`ifdef SMALL_CDB_FIFO_BYPASS_EN
        return (q.size() == 0) && in_valid && in_survives() && in_data.valid;
`else
        return 1'b0;
`endif
    endfunction

    task automatic predict();
        e_cnt = q.size();
        e_ir  = (q.size() < DEPTH);
        e_ov  = 1'b0;
        e_m   = '0;
        e_tag = '0;
        e_d   = '0;
        if (q.size() > 0) begin
            e_ov  = q[0].v && !(bra_done && bra_mispredict && ((q[0].m & bra_id) != 4'd0));
            e_m   = bra_done ? (q[0].m & ~bra_id) : q[0].m;
            e_tag = q[0].tag;
            e_d   = q[0].d;
        end else if (byp_case()) begin
            e_ov  = 1'b1;
            e_m   = bra_done ? (in_data.ebr_mask & ~bra_id) : in_data.ebr_mask;
            e_tag = in_data.tag;
            e_d   = in_data.data;
        end
    endtask

    // Advance the model by the rules seen at this edge, then the clock.
    task automatic tick();
        bit   pop_now;
        bit   push_now;
        ent_t e;
        predict();
        if (rst) begin
            q.delete();
        end else begin
            pop_now  = (q.size() > 0) && (!q[0].v || (out_pop && e_ov));
            push_now = in_valid && e_ir && in_survives() && !(byp_case() && out_pop);
            foreach (q[i]) begin
                if (bra_done) begin
                    if (bra_mispredict && ((q[i].m & bra_id) != 4'd0)) q[i].v = 1'b0;
                    q[i].m = q[i].m & ~bra_id;
                end
            end
            if (pop_now) void'(q.pop_front());
            if (push_now) begin
                e.v   = in_data.valid;
                e.m   = bra_done ? (in_data.ebr_mask & ~bra_id) : in_data.ebr_mask;
                e.tag = in_data.tag;
                e.d   = in_data.data;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input bit [3:0] m, input bit [5:0] tag, input bit pop,
                         input bit bd, input bit bm, input bit [3:0] id);
        in_valid          = iv;
        in_data.valid     = 1'b1;
        in_data.ebr_mask  = m;
        in_data.tag       = tag;
        in_data.data      = {10'h2A5, tag};
        out_pop           = pop;
        bra_done          = bd;
        bra_mispredict    = bm;
        bra_id            = id;
    endtask

    task automatic idle();
        drive(0, 4'd0, 6'd0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        drive(1, 4'd0, 6'd9, 1, 0, 0, 4'd0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_fill();
        for (int t = 1; t <= 4; t++) begin
            drive(1, 4'd0, 6'(t), 0, 0, 0, 4'd0);
            tick();
            n_checks++; if (count !== 3'(t)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count, t); end
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        drive(1, 4'd0, 6'd5, 0, 0, 0, 4'd0);
        tick();
        idle();
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_hold_count: got %0d want 4", count); end
        n_checks++; if (out_data.tag !== 6'd1) begin n_fail++; $display("FAIL fill_hold_head: got %0d want 1", out_data.tag); end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 4'd0, 6'd0, 1, 0, 0, 4'd0);
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_data.tag !== 6'(k)) begin
                n_fail++; $display("FAIL drain_order: got v=%b tag=%0d want v=1 tag=%0d", out_valid, out_data.tag, k);
            end
            tick();
            if (k == 1) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
            end
        end
        idle();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_squash();
        bit exp_v [3] = '{1'b0, 1'b1, 1'b0};
        drive(1, 4'b0001, 6'd11, 0, 0, 0, 4'd0); tick();
        drive(1, 4'b0010, 6'd12, 0, 0, 0, 4'd0); tick();
        drive(1, 4'b0001, 6'd13, 0, 0, 0, 4'd0); tick();
        drive(0, 4'd0, 6'd0, 0, 1, 1, 4'b0001);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL squash_head_now: got %b want 0", out_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'd0, 6'd0, 1, 0, 0, 4'd0);
            #1;
            n_checks++; if (out_valid !== exp_v[k]) begin n_fail++; $display("FAIL squash_offer%0d: got %b want %b", k, out_valid, exp_v[k]); end
            if (exp_v[k]) begin
                n_checks++; if (out_data.tag !== 6'd12) begin n_fail++; $display("FAIL squash_tag: got %0d want 12", out_data.tag); end
            end
            tick();
        end
        idle();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL squash_count: got %0d want 0", count); end
    endtask

    task automatic test_resolve();
        drive(1, 4'b0100, 6'd21, 0, 0, 0, 4'd0); tick();
        drive(0, 4'd0, 6'd0, 0, 1, 0, 4'b0100);
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data.ebr_mask !== 4'b0000) begin
            n_fail++; $display("FAIL resolve_now: got v=%b mask=%b want v=1 mask=0000", out_valid, out_data.ebr_mask);
        end
        tick();
        idle();
        #1;
        n_checks++; if (out_data.ebr_mask !== 4'b0000) begin n_fail++; $display("FAIL resolve_after: got %b want 0000", out_data.ebr_mask); end
        drive(0, 4'd0, 6'd0, 1, 0, 0, 4'd0); tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 4'd0, 6'd31, 0, 0, 0, 4'd0); tick();
        drive(1, 4'd0, 6'd32, 0, 0, 0, 4'd0); tick();
        drive(1, 4'd0, 6'd33, 1, 0, 0, 4'd0);
        #1;
        n_checks++; if (out_data.tag !== 6'd31) begin n_fail++; $display("FAIL b2b_head: got %0d want 31", out_data.tag); end
        tick();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", count); end
        drive(1, 4'b0010, 6'd34, 0, 1, 1, 4'b0010);
        tick();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_killed_push: got %0d want 2", count); end
        for (int k = 0; k < 2; k++) begin
            drive(0, 4'd0, 6'd0, 1, 0, 0, 4'd0);
            #1;
            n_checks++; if (out_data.tag !== 6'(32 + k)) begin n_fail++; $display("FAIL b2b_order: got %0d want %0d", out_data.tag, 32 + k); end
            tick();
        end
    endtask

    task automatic test_empty_push_pop();
        drive(1, 4'd0, 6'd41, 1, 0, 0, 4'd0);
        #1;
`ifdef SMALL_CDB_FIFO_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1 || out_data.tag !== 6'd41) begin
            n_fail++; $display("FAIL bypass_offer: got v=%b tag=%0d want v=1 tag=41", out_valid, out_data.tag);
        end
        tick();
        idle();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", count); end
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_offer: got %b want 0", out_valid); end
        tick();
        idle();
        #1;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL nobypass_count: got %0d want 1", count); end
        drive(0, 4'd0, 6'd0, 1, 0, 0, 4'd0); tick();
`endif
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst              = ($urandom_range(0, 99) == 0);
            in_valid         = $urandom_range(0, 1);
            in_data.valid    = ($urandom_range(0, 7) != 0);
            in_data.ebr_mask = 4'($urandom);
            in_data.tag      = 6'($urandom);
            in_data.data     = 16'($urandom);
            out_pop          = ($urandom_range(0, 2) != 0);
            bra_done         = ($urandom_range(0, 3) == 0);
            bra_mispredict   = $urandom_range(0, 1);
            bra_id           = 4'b0001 << $urandom_range(0, 3);
            #1;
            predict();
            n_checks++; if (out_valid !== e_ov || in_ready !== e_ir || count !== 3'(e_cnt)) begin
                n_fail++; $display("FAIL rand_ctrl c=%0d: got v=%b rdy=%b cnt=%0d want v=%b rdy=%b cnt=%0d",
                                   c, out_valid, in_ready, count, e_ov, e_ir, e_cnt);
            end
            if (e_ov) begin
                n_checks++; if (out_data.tag !== e_tag || out_data.ebr_mask !== e_m || out_data.data !== e_d) begin
                    n_fail++; $display("FAIL rand_data c=%0d: got tag=%0d m=%b d=%h want tag=%0d m=%b d=%h",
                                       c, out_data.tag, out_data.ebr_mask, out_data.data, e_tag, e_m, e_d);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        in_data = '0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_squash();
        test_resolve();
        test_back_to_back();
        test_empty_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
